// File: rtl/risc_mgmt_arbiter.sv
// risc_mgmt_arbiter: grants custom instructions to one RISC-MGMT extension and sequences its memory accesses and faults
module risc_mgmt_arbiter #(
  parameter int NUM_EXT = 4,
  parameter int WORD_W  = 32,
  parameter int TIMEOUT = 256
) (
  input  logic                      CLK,
  input  logic                      nRST,
  input  logic                      insn_valid,
  input  logic [NUM_EXT-1:0]        ext_claim,
  input  logic [NUM_EXT-1:0]        ext_done,
  input  logic [NUM_EXT-1:0]        ext_exception,
  input  logic [NUM_EXT-1:0]        ext_mem_req,
  input  logic [NUM_EXT-1:0]        ext_mem_wen,
  input  logic [NUM_EXT*WORD_W-1:0] ext_mem_addr,
  input  logic [NUM_EXT*WORD_W-1:0] ext_mem_store,
  input  logic                      flush,
  input  logic                      mem_busy,
  input  logic [WORD_W-1:0]         mem_load,
  output logic                      mem_ren,
  output logic                      mem_wen,
  output logic [WORD_W-1:0]         mem_addr,
  output logic [WORD_W-1:0]         mem_store,
  output logic [WORD_W-1:0]         ext_mem_load,
  output logic [NUM_EXT-1:0]        ext_mem_ack,
  output logic [NUM_EXT-1:0]        ex_token,
  output logic                      active_insn,
  output logic                      decode_bubble,
  output logic                      execute_stall,
  output logic                      exception,
  output logic [NUM_EXT-1:0]        ex_cause
);
  localparam int OW = NUM_EXT > 1 ? $clog2(NUM_EXT) : 1;
  localparam int CW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {IDLE, EXEC, MEM_WAIT} state_t;
  state_t             state_q, state_d;
  logic [OW-1:0]      owner_q, owner_d, claim_idx;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               flush_pend_q, flush_pend_d;
  logic [NUM_EXT-1:0] token_q, token_d, ack_q, ack_d, cause_q, cause_d, owner_oh;
  logic               wen_q, wen_d, exc_q, exc_d, one_claim, multi_claim, to_idle;
  logic [WORD_W-1:0]  addr_q, addr_d, store_q, store_d, load_q, load_d;
  assign one_claim   = ext_claim != '0 && (ext_claim & (ext_claim - NUM_EXT'(1))) == '0;
  assign multi_claim = ext_claim != '0 && !one_claim;
  assign owner_oh    = NUM_EXT'(1) << owner_q;
  // lowest set claim bit gives the owner index (only used when exactly one bit is set)
  always_comb begin
    claim_idx = '0;
    for (int i = NUM_EXT - 1; i >= 0; i--) if (ext_claim[i]) claim_idx = OW'(i);
  end
  // next-state, grant bookkeeping and registered pulse generation
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    cnt_d        = cnt_q;
    flush_pend_d = flush_pend_q;
    token_d      = token_q;
    wen_d        = wen_q;
    addr_d       = addr_q;
    store_d      = store_q;
    load_d       = load_q;
    ack_d        = '0;
    exc_d        = 1'b0;
    cause_d      = '0;
    to_idle      = 1'b0;
    case (state_q)
      IDLE: begin
        if (insn_valid && one_claim) begin
          state_d = EXEC;
          owner_d = claim_idx;
          token_d = ext_claim;
          cnt_d   = '0;
        end else if (insn_valid && multi_claim) begin
          exc_d   = 1'b1;
          cause_d = ext_claim;
        end
      end
      EXEC: begin
        if (flush) to_idle = 1'b1;
        else if (ext_exception[owner_q]) begin
          exc_d   = 1'b1;
          cause_d = owner_oh;
          to_idle = 1'b1;
        end else if (ext_done[owner_q]) to_idle = 1'b1;
        else if (ext_mem_req[owner_q]) begin
          state_d = MEM_WAIT;
          wen_d   = ext_mem_wen[owner_q];
          addr_d  = ext_mem_addr[owner_q*WORD_W +: WORD_W];
          store_d = ext_mem_store[owner_q*WORD_W +: WORD_W];
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          exc_d   = 1'b1;
          cause_d = owner_oh;
          to_idle = 1'b1;
        end else cnt_d = cnt_q + CW'(1);
      end
      MEM_WAIT: begin
        if (!mem_busy) begin
          load_d = mem_load;
          if (flush_pend_q || flush) to_idle = 1'b1;
          else begin
            ack_d   = owner_oh;
            state_d = EXEC;
          end
        end else if (flush) flush_pend_d = 1'b1;
      end
      default: to_idle = 1'b1;
    endcase
    if (to_idle) begin
      state_d      = IDLE;
      owner_d      = '0;
      cnt_d        = '0;
      flush_pend_d = 1'b0;
      token_d      = '0;
    end
  end
  // state and datapath registers, cleared asynchronously
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= IDLE;
      owner_q      <= '0;
      cnt_q        <= '0;
      flush_pend_q <= 1'b0;
      token_q      <= '0;
      wen_q        <= 1'b0;
      addr_q       <= '0;
      store_q      <= '0;
      load_q       <= '0;
      ack_q        <= '0;
      exc_q        <= 1'b0;
      cause_q      <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      cnt_q        <= cnt_d;
      flush_pend_q <= flush_pend_d;
      token_q      <= token_d;
      wen_q        <= wen_d;
      addr_q       <= addr_d;
      store_q      <= store_d;
      load_q       <= load_d;
      ack_q        <= ack_d;
      exc_q        <= exc_d;
      cause_q      <= cause_d;
    end
  end
  assign mem_ren       = state_q == MEM_WAIT && !wen_q;
  assign mem_wen       = state_q == MEM_WAIT && wen_q;
  assign mem_addr      = addr_q;
  assign mem_store     = store_q;
  assign ext_mem_load  = load_q;
  assign ext_mem_ack   = ack_q;
  assign ex_token      = token_q;
  assign active_insn   = state_q != IDLE;
  assign decode_bubble = state_q != IDLE;
  assign execute_stall = (state_q == EXEC && state_d != IDLE) || state_q == MEM_WAIT;
  assign exception     = exc_q;
  assign ex_cause      = cause_q;
endmodule

// File: tb/tb_risc_mgmt_arbiter.sv
// tb_risc_mgmt_arbiter: directed scenario checks of the extension arbiter
module tb_risc_mgmt_arbiter;
  localparam int N = 4;
  localparam int W = 32;
  logic CLK, nRST, insn_valid, flush, mem_busy;
  logic [N-1:0] ext_claim, ext_done, ext_exception, ext_mem_req, ext_mem_wen;
  logic [N*W-1:0] ext_mem_addr, ext_mem_store;
  logic [W-1:0] mem_load, mem_addr, mem_store, ext_mem_load;
  logic mem_ren, mem_wen, active_insn, decode_bubble, execute_stall, exception;
  logic [N-1:0] ext_mem_ack, ex_token, ex_cause;
  int vecs = 0;
  int errs = 0;

  risc_mgmt_arbiter #(.NUM_EXT(N), .WORD_W(W), .TIMEOUT(8)) dut (
    .CLK(CLK), .nRST(nRST), .insn_valid(insn_valid), .ext_claim(ext_claim),
    .ext_done(ext_done), .ext_exception(ext_exception), .ext_mem_req(ext_mem_req),
    .ext_mem_wen(ext_mem_wen), .ext_mem_addr(ext_mem_addr), .ext_mem_store(ext_mem_store),
    .flush(flush), .mem_busy(mem_busy), .mem_load(mem_load), .mem_ren(mem_ren),
    .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_store(mem_store),
    .ext_mem_load(ext_mem_load), .ext_mem_ack(ext_mem_ack), .ex_token(ex_token),
    .active_insn(active_insn), .decode_bubble(decode_bubble),
    .execute_stall(execute_stall), .exception(exception), .ex_cause(ex_cause));

  initial begin
    CLK = 0;
    forever #5 CLK = ~CLK;
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs;
    insn_valid = 0; flush = 0; mem_busy = 0; mem_load = '0;
    ext_claim = '0; ext_done = '0; ext_exception = '0; ext_mem_req = '0;
    ext_mem_wen = '0; ext_mem_addr = '0; ext_mem_store = '0;
  endtask

  task automatic claim(input logic [N-1:0] c);
    insn_valid = 1; ext_claim = c;
    tick();
    insn_valid = 0; ext_claim = '0;
  endtask

  task automatic test_reset;
    nRST = 0;
    clear_inputs();
    #3;
    if ({mem_ren, mem_wen, ex_token, ext_mem_ack, active_insn, decode_bubble, execute_stall, exception, ex_cause} !== '0) begin
      errs++; $display("FAIL reset_ctrl got=%b exp=0", {mem_ren, mem_wen, ex_token, ext_mem_ack, active_insn, decode_bubble, execute_stall, exception, ex_cause});
    end
    vecs++;
    if ({ext_mem_load, mem_addr, mem_store} !== '0) begin
      errs++; $display("FAIL reset_data got=%h exp=0", {ext_mem_load, mem_addr, mem_store});
    end
    vecs++;
    @(negedge CLK);
    nRST = 1;
    tick();
  endtask

  task automatic test_single;
    claim(4'b0100);
    #1;
    if ({ex_token, execute_stall, decode_bubble} !== {4'b0100, 1'b1, 1'b1}) begin
      errs++; $display("FAIL single_c1 got=%b exp=%b", {ex_token, execute_stall, decode_bubble}, {4'b0100, 1'b1, 1'b1});
    end
    vecs++;
    tick();
    ext_done = 4'b0001;
    #1;
    if ({ex_token, execute_stall} !== {4'b0100, 1'b1}) begin
      errs++; $display("FAIL single_c2_nonowner_done got=%b exp=%b", {ex_token, execute_stall}, {4'b0100, 1'b1});
    end
    vecs++;
    tick();
    ext_done = 4'b0100;
    #1;
    if ({ex_token, execute_stall, active_insn} !== {4'b0100, 1'b0, 1'b1}) begin
      errs++; $display("FAIL single_c3_done got=%b exp=%b", {ex_token, execute_stall, active_insn}, {4'b0100, 1'b0, 1'b1});
    end
    vecs++;
    tick();
    ext_done = '0;
    if ({ex_token, exception, active_insn} !== '0) begin
      errs++; $display("FAIL single_end got=%b exp=0", {ex_token, exception, active_insn});
    end
    vecs++;
  endtask

  task automatic test_conflict;
    claim(4'b0110);
    if ({exception, ex_cause, ex_token, active_insn} !== {1'b1, 4'b0110, 4'b0000, 1'b0}) begin
      errs++; $display("FAIL conflict_pulse got=%b exp=%b", {exception, ex_cause, ex_token, active_insn}, {1'b1, 4'b0110, 4'b0000, 1'b0});
    end
    vecs++;
    tick();
    if ({exception, ex_token} !== '0) begin
      errs++; $display("FAIL conflict_once got=%b exp=0", {exception, ex_token});
    end
    vecs++;
  endtask

  task automatic test_mem_load;
    claim(4'b0010);
    ext_mem_req = 4'b0011;
    ext_mem_addr[0*W +: W] = 32'hAAAA_0000;
    ext_mem_addr[1*W +: W] = 32'h0000_1000;
    mem_busy = 1;
    tick();
    ext_mem_req = '0;
    ext_mem_addr = '0;
    for (int i = 0; i < 4; i++) begin
      if ({mem_ren, mem_wen, mem_addr, ext_mem_ack} !== {1'b1, 1'b0, 32'h0000_1000, 4'b0000}) begin
        errs++; $display("FAIL load_wait%0d got=%h exp=%h", i, {mem_ren, mem_wen, mem_addr, ext_mem_ack}, {1'b1, 1'b0, 32'h0000_1000, 4'b0000});
      end
      vecs++;
      tick();
    end
    mem_busy = 0;
    mem_load = 32'hDEAD_BEEF;
    tick();
    mem_load = '0;
    if ({ext_mem_ack, ext_mem_load, mem_ren, active_insn} !== {4'b0010, 32'hDEAD_BEEF, 1'b0, 1'b1}) begin
      errs++; $display("FAIL load_ack got=%h exp=%h", {ext_mem_ack, ext_mem_load, mem_ren, active_insn}, {4'b0010, 32'hDEAD_BEEF, 1'b0, 1'b1});
    end
    vecs++;
    tick();
    if ({ext_mem_ack, ex_token, ext_mem_load} !== {4'b0000, 4'b0010, 32'hDEAD_BEEF}) begin
      errs++; $display("FAIL load_ack_once got=%h exp=%h", {ext_mem_ack, ex_token, ext_mem_load}, {4'b0000, 4'b0010, 32'hDEAD_BEEF});
    end
    vecs++;
    ext_done = 4'b0010;
    tick();
    ext_done = '0;
  endtask

  task automatic test_timeout;
    claim(4'b1000);
    for (int i = 0; i < 8; i++) begin
      if ({exception, ex_token, execute_stall} !== {1'b0, 4'b1000, i < 7}) begin
        errs++; $display("FAIL timeout_exec%0d got=%b exp=%b", i, {exception, ex_token, execute_stall}, {1'b0, 4'b1000, i < 7});
      end
      vecs++;
      tick();
    end
    if ({exception, ex_cause, ex_token, active_insn} !== {1'b1, 4'b1000, 4'b0000, 1'b0}) begin
      errs++; $display("FAIL timeout_fire got=%b exp=%b", {exception, ex_cause, ex_token, active_insn}, {1'b1, 4'b1000, 4'b0000, 1'b0});
    end
    vecs++;
    tick();
  endtask

  task automatic test_flush_mem;
    claim(4'b0001);
    ext_mem_req = 4'b0001;
    ext_mem_wen = 4'b0001;
    ext_mem_addr[0*W +: W] = 32'h0000_2000;
    ext_mem_store[0*W +: W] = 32'h1234_5678;
    mem_busy = 1;
    tick();
    ext_mem_req = '0; ext_mem_wen = '0; ext_mem_store = '0;
    flush = 1;
    if ({mem_wen, mem_ren, mem_store, mem_addr} !== {1'b1, 1'b0, 32'h1234_5678, 32'h0000_2000}) begin
      errs++; $display("FAIL flush_store_c1 got=%h exp=%h", {mem_wen, mem_ren, mem_store, mem_addr}, {1'b1, 1'b0, 32'h1234_5678, 32'h0000_2000});
    end
    vecs++;
    tick();
    flush = 0;
    if ({mem_wen, active_insn} !== 2'b11) begin
      errs++; $display("FAIL flush_store_c2 got=%b exp=11", {mem_wen, active_insn});
    end
    vecs++;
    tick();
    mem_busy = 0;
    if (mem_wen !== 1'b1) begin
      errs++; $display("FAIL flush_store_c3 got=%b exp=1", mem_wen);
    end
    vecs++;
    tick();
    if ({ext_mem_ack, ex_token, active_insn, mem_wen} !== '0) begin
      errs++; $display("FAIL flush_noack got=%b exp=0", {ext_mem_ack, ex_token, active_insn, mem_wen});
    end
    vecs++;
  endtask

  task automatic test_priority;
    claim(4'b0001);
    flush = 1; ext_done = 4'b0001; ext_exception = 4'b0001;
    tick();
    flush = 0; ext_done = '0; ext_exception = '0;
    if ({exception, active_insn, ex_token} !== '0) begin
      errs++; $display("FAIL flush_prio got=%b exp=0", {exception, active_insn, ex_token});
    end
    vecs++;
    claim(4'b0100);
    ext_exception = 4'b0001;
    tick();
    ext_exception = 4'b0101; ext_done = 4'b0100;
    tick();
    ext_exception = '0; ext_done = '0;
    if ({exception, ex_cause, active_insn} !== {1'b1, 4'b0100, 1'b0}) begin
      errs++; $display("FAIL ext_fault got=%b exp=%b", {exception, ex_cause, active_insn}, {1'b1, 4'b0100, 1'b0});
    end
    vecs++;
  endtask

  task automatic test_back_to_back;
    claim(4'b0001);
    ext_done = 4'b0001;
    tick();
    ext_done = '0;
    claim(4'b1000);
    if ({ex_token, exception} !== {4'b1000, 1'b0}) begin
      errs++; $display("FAIL b2b_grant got=%b exp=%b", {ex_token, exception}, {4'b1000, 1'b0});
    end
    vecs++;
    ext_done = 4'b1000;
    tick();
    ext_done = '0;
  endtask

  task automatic test_async_reset;
    claim(4'b0100);
    ext_mem_req = 4'b0100;
    mem_busy = 1;
    tick();
    ext_mem_req = '0;
    if (mem_ren !== 1'b1) begin
      errs++; $display("FAIL arst_pre got=%b exp=1", mem_ren);
    end
    vecs++;
    #2 nRST = 0;
    #1;
    if ({mem_ren, mem_wen, ex_token, active_insn} !== '0) begin
      errs++; $display("FAIL arst_drop got=%b exp=0", {mem_ren, mem_wen, ex_token, active_insn});
    end
    vecs++;
    #1 nRST = 1;
    mem_busy = 0;
    tick();
    claim(4'b0010);
    if ({ex_token, active_insn} !== {4'b0010, 1'b1}) begin
      errs++; $display("FAIL arst_regrant got=%b exp=%b", {ex_token, active_insn}, {4'b0010, 1'b1});
    end
    vecs++;
    ext_done = 4'b0010;
    tick();
    ext_done = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_conflict();
    test_mem_load();
    test_timeout();
    test_flush_mem();
    test_priority();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
